// File: rtl/hazard_unit.sv
`default_nettype none
// ============================================================================
//  Module      : hazard_unit
//  Description : Pipeline hazard detection for a 5-stage MIPS-style core.
//                Detects load-use, branch-compare and multiply/divide
//                hazards and drives stall/flush controls. Tracks the busy
//                window of the multi-cycle mult/div unit and keeps a
//                saturating count of stalled cycles.
//  Ports       :
//    clk, rst                  clock, asynchronous active-low reset
//    rsD, rtD                  Decode source registers
//    branchD, mfhiloD,
//    mdStartD, pcSrcD          Decode instruction class / taken branch
//    rtE, writeRegisterE       Execute load target / destination
//    regWriteE, memToRegE,
//    mdStartE                  Execute control
//    writeRegisterM, memToRegM Memory-stage destination / load flag
//    clrCount                  synchronous clear of stallCount
//    stallF, stallD, flushE    stall PC and F/D register, bubble into D/E
//    flushD                    clear F/D register on taken branch
//    mdBusy, mdDone            mult/div busy level and completion pulse
//    stallCount                saturating stalled-cycle counter
//  Revision    : 1.0 - initial release
// ============================================================================
module hazard_unit #(
    parameter int MD_LATENCY = 32,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [4:0]           rsD,
    input  logic [4:0]           rtD,
    input  logic                 branchD,
    input  logic                 mfhiloD,
    input  logic                 mdStartD,
    input  logic                 pcSrcD,
    input  logic [4:0]           rtE,
    input  logic [4:0]           writeRegisterE,
    input  logic                 regWriteE,
    input  logic                 memToRegE,
    input  logic                 mdStartE,
    input  logic [4:0]           writeRegisterM,
    input  logic                 memToRegM,
    input  logic                 clrCount,
    output logic                 stallF,
    output logic                 stallD,
    output logic                 flushE,
    output logic                 flushD,
    output logic                 mdBusy,
    output logic                 mdDone,
    output logic [CNT_WIDTH-1:0] stallCount
);

    localparam int                   MD_CW   = $clog2(MD_LATENCY + 1);
    localparam logic [MD_CW-1:0]     MD_LOAD = MD_CW'(MD_LATENCY);
    localparam logic [MD_CW-1:0]     MD_ONE  = MD_CW'(1);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

    // ------------------------------------------------------------------
    // Hazard detection (purely combinational, zero latency)
    // ------------------------------------------------------------------
    logic w_lw_stall;
    logic w_br_stall;
    logic w_md_stall;
    logic w_stall;
    logic w_exe_hit;
    logic w_mem_hit;

    logic             md_busy_q, md_busy_d;
    logic             md_done_q, md_done_d;
    logic [MD_CW-1:0] md_cnt_q,  md_cnt_d;
    logic [CNT_WIDTH-1:0] stall_cnt_q, stall_cnt_d;

    // Register 0 is hardwired to zero, so a nonzero check gates every match.
    assign w_lw_stall = memToRegE && (rtE != 5'd0) && ((rtE == rsD) || (rtE == rtD));

    assign w_exe_hit  = regWriteE && (writeRegisterE != 5'd0) &&
                        ((writeRegisterE == rsD) || (writeRegisterE == rtD));
    // A load in Memory has no data yet, so a Decode-stage compare must wait.
    assign w_mem_hit  = memToRegM && (writeRegisterM != 5'd0) &&
                        ((writeRegisterM == rsD) || (writeRegisterM == rtD));
    assign w_br_stall = branchD && (w_exe_hit || w_mem_hit);

    // mdStartE counts as busy so a back-to-back HI/LO access cannot slip past.
    assign w_md_stall = (mfhiloD || mdStartD) && (md_busy_q || mdStartE);

    assign w_stall = w_lw_stall || w_br_stall || w_md_stall;

    assign stallF     = w_stall;
    assign stallD     = w_stall;
    assign flushE     = w_stall;
    assign flushD     = pcSrcD && !w_stall;

    assign mdBusy     = md_busy_q;
    assign mdDone     = md_done_q;
    assign stallCount = stall_cnt_q;

    // ------------------------------------------------------------------
    // Mult/div busy tracker and stall counter next-state
    // ------------------------------------------------------------------
    always_comb begin
        md_busy_d   = md_busy_q;
        md_done_d   = 1'b0;
        md_cnt_d    = md_cnt_q;
        stall_cnt_d = stall_cnt_q;

        if (md_busy_q) begin
            // Starts arriving while busy are ignored: no reload, no extension.
            md_cnt_d = md_cnt_q - MD_ONE;
            if (md_cnt_q == MD_ONE) begin
                md_busy_d = 1'b0;
                md_done_d = 1'b1;
            end
        end else if (mdStartE) begin
            md_cnt_d  = MD_LOAD;
            md_busy_d = 1'b1;
        end

        if (clrCount) begin
            stall_cnt_d = '0;
        end else if (w_stall && (stall_cnt_q != CNT_MAX)) begin
            stall_cnt_d = stall_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            md_busy_q   <= 1'b0;
            md_done_q   <= 1'b0;
            md_cnt_q    <= '0;
            stall_cnt_q <= '0;
        end else begin
            md_busy_q   <= md_busy_d;
            md_done_q   <= md_done_d;
            md_cnt_q    <= md_cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_hazard_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_hazard_unit
//  Description : Scoreboard bench for hazard_unit. A driver applies directed
//                and random vectors and queues the expected outputs computed
//                from a timeline model of the mult/div unit; a monitor pops
//                and compares on the falling edge.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_hazard_unit;

    localparam int L    = 4;
    localparam int CW   = 4;
    localparam int CMAX = (1 << CW) - 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst;
    logic [4:0]    rsD, rtD, rtE, writeRegisterE, writeRegisterM;
    logic          branchD, mfhiloD, mdStartD, pcSrcD;
    logic          regWriteE, memToRegE, mdStartE, memToRegM, clrCount;
    logic          stallF, stallD, flushE, flushD, mdBusy, mdDone;
    logic [CW-1:0] stallCount;

    hazard_unit #(.MD_LATENCY(L), .CNT_WIDTH(CW)) dut (
        .clk(clk), .rst(rst),
        .rsD(rsD), .rtD(rtD), .branchD(branchD), .mfhiloD(mfhiloD),
        .mdStartD(mdStartD), .pcSrcD(pcSrcD),
        .rtE(rtE), .writeRegisterE(writeRegisterE), .regWriteE(regWriteE),
        .memToRegE(memToRegE), .mdStartE(mdStartE),
        .writeRegisterM(writeRegisterM), .memToRegM(memToRegM),
        .clrCount(clrCount),
        .stallF(stallF), .stallD(stallD), .flushE(flushE), .flushD(flushD),
        .mdBusy(mdBusy), .mdDone(mdDone), .stallCount(stallCount)
    );

    typedef struct {
        logic [4:0] rsD, rtD, rtE, wrE, wrM;
        logic branchD, mfhiloD, mdStartD, pcSrcD;
        logic regWriteE, memToRegE, mdStartE, memToRegM, clrCount;
    } stim_t;

    typedef struct {
        bit    stall, flushD, busy, done;
        int    cnt;
        string tag;
    } exp_t;

    exp_t  q[$];
    stim_t cur;
    int    vectors = 0;
    int    miscompares = 0;

    // Model: the unit is busy on the L cycles following the accepting edge,
    // and done on the cycle after that. Tracked as edge timestamps.
    int e_idx   = 0;
    int s_start = -1000;
    int m_cnt   = 0;

    function automatic bit m_busy();
        return ((e_idx - s_start) >= 0) && ((e_idx - s_start) < L);
    endfunction

    function automatic bit m_done();
        return (e_idx - s_start) == L;
    endfunction

    function automatic bit hit(logic [4:0] r, stim_t s);
        return (r != 5'd0) && ((r == s.rsD) || (r == s.rtD));
    endfunction

    function automatic bit m_stall(stim_t s, bit busy);
        bit lw = s.memToRegE && hit(s.rtE, s);
        bit br = s.branchD && ((s.regWriteE && hit(s.wrE, s)) || (s.memToRegM && hit(s.wrM, s)));
        bit md = (s.mfhiloD || s.mdStartD) && (busy || s.mdStartE);
        return lw || br || md;
    endfunction

    function automatic stim_t zs();
        stim_t s;
        s.rsD = 0; s.rtD = 0; s.rtE = 0; s.wrE = 0; s.wrM = 0;
        s.branchD = 0; s.mfhiloD = 0; s.mdStartD = 0; s.pcSrcD = 0;
        s.regWriteE = 0; s.memToRegE = 0; s.mdStartE = 0; s.memToRegM = 0;
        s.clrCount = 0;
        return s;
    endfunction

    function automatic stim_t rs();
        stim_t s;
        s.rsD = 5'($urandom_range(0, 3)); s.rtD = 5'($urandom_range(0, 3));
        s.rtE = 5'($urandom_range(0, 3)); s.wrE = 5'($urandom_range(0, 3));
        s.wrM = 5'($urandom_range(0, 3));
        s.branchD   = ($urandom_range(0, 2) == 0);
        s.mfhiloD   = ($urandom_range(0, 3) == 0);
        s.mdStartD  = ($urandom_range(0, 3) == 0);
        s.pcSrcD    = ($urandom_range(0, 1) == 0);
        s.regWriteE = ($urandom_range(0, 1) == 0);
        s.memToRegE = ($urandom_range(0, 2) == 0);
        s.mdStartE  = ($urandom_range(0, 4) == 0);
        s.memToRegM = ($urandom_range(0, 2) == 0);
        s.clrCount  = ($urandom_range(0, 15) == 0);
        return s;
    endfunction

    task automatic drive(stim_t s);
        rsD = s.rsD; rtD = s.rtD; rtE = s.rtE;
        writeRegisterE = s.wrE; writeRegisterM = s.wrM;
        branchD = s.branchD; mfhiloD = s.mfhiloD; mdStartD = s.mdStartD;
        pcSrcD = s.pcSrcD; regWriteE = s.regWriteE; memToRegE = s.memToRegE;
        mdStartE = s.mdStartE; memToRegM = s.memToRegM; clrCount = s.clrCount;
    endtask

    task automatic push(string tag);
        exp_t x;
        bit   b;
        b        = rst ? m_busy() : 1'b0;
        x.stall  = m_stall(cur, b);
        x.flushD = cur.pcSrcD && !x.stall;
        x.busy   = b;
        x.done   = rst ? m_done() : 1'b0;
        x.cnt    = rst ? m_cnt : 0;
        x.tag    = tag;
        q.push_back(x);
    endtask

    // Advance the model across the rising edge using the inputs held over it.
    task automatic model_edge();
        bit pb;
        bit st;
        if (rst) begin
            pb = m_busy();
            st = m_stall(cur, pb);
            e_idx++;
            if (cur.mdStartE && !pb) s_start = e_idx;
            if (cur.clrCount) m_cnt = 0;
            else if (st && m_cnt < CMAX) m_cnt++;
        end
    endtask

    task automatic step(stim_t s, string tag);
        @(posedge clk);
        model_edge();
        #1;
        cur = s;
        drive(cur);
        push(tag);
    endtask

    // Assert reset between edges so its effect is seen before the next edge.
    task automatic reset_mid(int ncyc, string tag);
        @(posedge clk);
        model_edge();
        #3;
        rst = 1'b0;
        s_start = -1000;
        m_cnt = 0;
        push(tag);
        repeat (ncyc) begin
            @(posedge clk); #1; push(tag);
        end
        @(posedge clk); #1;
        rst = 1'b1;
        push({tag, "_rel"});
    endtask

    task automatic check(exp_t x);
        bit bad = 0;
        vectors++;
        if (stallF !== x.stall) begin bad = 1; $display("FAIL %s stallF got %b want %b", x.tag, stallF, x.stall); end
        if (stallD !== x.stall) begin bad = 1; $display("FAIL %s stallD got %b want %b", x.tag, stallD, x.stall); end
        if (flushE !== x.stall) begin bad = 1; $display("FAIL %s flushE got %b want %b", x.tag, flushE, x.stall); end
        if (flushD !== x.flushD) begin bad = 1; $display("FAIL %s flushD got %b want %b", x.tag, flushD, x.flushD); end
        if (mdBusy !== x.busy) begin bad = 1; $display("FAIL %s mdBusy got %b want %b", x.tag, mdBusy, x.busy); end
        if (mdDone !== x.done) begin bad = 1; $display("FAIL %s mdDone got %b want %b", x.tag, mdDone, x.done); end
        if ($isunknown(stallCount) || int'(stallCount) != x.cnt) begin
            bad = 1; $display("FAIL %s stallCount got %0d want %0d", x.tag, stallCount, x.cnt);
        end
        if (bad) miscompares++;
    endtask

    // Monitor: compare every queued expectation against the settled outputs.
    initial begin
        forever begin
            @(negedge clk);
            while (q.size() > 0) begin
                exp_t x;
                x = q.pop_front();
                check(x);
            end
        end
    end

    initial begin
        stim_t s;
        rst = 1'b0;
        cur = zs();
        drive(cur);
        #1 push("reset");
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        push("reset_rel");

        // Load-use hazard and register-0 exclusion
        s = zs(); s.memToRegE = 1; s.rtE = 8; s.rsD = 8;  step(s, "lw_hit");
        s = zs(); s.memToRegE = 1; s.rtE = 8; s.rtD = 8;  step(s, "lw_hit_rt");
        s = zs(); s.memToRegE = 1;                        step(s, "lw_r0");
        s = zs();                                         step(s, "idle");

        // Branch compare hazards and taken-branch flush
        s = zs(); s.branchD = 1; s.regWriteE = 1; s.wrE = 5; s.rtD = 5; step(s, "br_exe");
        s = zs(); s.branchD = 1; s.memToRegM = 1; s.wrM = 5; s.rtD = 5; step(s, "br_mem");
        s = zs(); s.branchD = 1; s.regWriteE = 1;                       step(s, "br_r0");
        s = zs(); s.pcSrcD = 1;                                         step(s, "taken");
        s = zs(); s.pcSrcD = 1; s.branchD = 1; s.regWriteE = 1; s.wrE = 3; s.rsD = 3;
        step(s, "taken_stall");

        // Saturation and clear priority
        s = zs(); s.clrCount = 1;                         step(s, "clr");
        s = zs(); s.memToRegE = 1; s.rtE = 2; s.rsD = 2;
        repeat (20) step(s, "sat");
        s.clrCount = 1;                                   step(s, "clr_stall");
        s = zs();                                         step(s, "after_clr");

        // Mult/div busy window, HI/LO stall, ignored restart
        s = zs(); s.mdStartE = 1;                         step(s, "md_start");
        s = zs(); s.mfhiloD = 1;                          step(s, "md_b1");
        s = zs(); s.mdStartE = 1;                         step(s, "md_restart");
        s = zs(); s.mdStartD = 1;                         step(s, "md_b3");
        s = zs();
        repeat (5) step(s, "md_tail");
        s = zs(); s.mfhiloD = 1; s.mdStartE = 1;          step(s, "md_fwd");
        s = zs();
        repeat (6) step(s, "md_idle");

        // Asynchronous reset in the middle of a busy window
        s = zs(); s.mdStartE = 1;                         step(s, "rs_start");
        s = zs();
        repeat (2) step(s, "rs_busy");
        reset_mid(1, "rs_mid");
        s = zs(); s.mdStartE = 1;                         step(s, "rs_restart");
        s = zs();
        repeat (7) step(s, "rs_run");

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            step(rs(), "rand");
            if (i == 200) reset_mid(2, "rand_rst");
        end

        @(negedge clk);
        #1;
        if (q.size() != 0) begin
            $display("FAIL drain %0d expectations left, want 0", q.size());
            miscompares++;
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
